uart_rx_oversampled: RTL and testbench
======================================

// Module: uart_rx_oversampled
// PURPOSE
//  Asynchronous-serial UART receiver, 8N1 by default, optional parity. Samples the line on the
//  16x-oversample enable from the baud generator's RX tick output. Validates the start bit at
//  mid-bit and samples each data, parity and stop bit at its centre. Presents each byte as a
//  one-cycle rx_valid pulse; this is the receive end paired with the UART transmitter.
// PARAMETERS
//  DATA_BITS   8   data bits per frame, LSB first (5..9)
//  OVERSAMPLE  16  rx_tick pulses per bit period (power of 2, >=8)
//  PARITY_EN   0   1 = one parity bit after data
//  PARITY_ODD  0   1 = odd parity, 0 = even (ignored if PARITY_EN=0)
// PORTS
//  clk         in   1          system clock
//  reset       in   1          asynchronous, active-high
//  rx_tick     in   1          1-cycle enable at OVERSAMPLE x baud
//  rx          in   1          serial line, asynchronous to clk, idle high
//  rx_data     out  DATA_BITS  last received word
//  rx_valid    out  1          1-cycle pulse, rx_data/flags valid
//  frame_err   out  1          stop bit sampled 0 for last frame
//  parity_err  out  1          parity mismatch for last frame (0 if PARITY_EN=0)
//  busy        out  1          high in any state other than IDLE
// BEHAVIOUR
//  - Reset: sync FFs=1, state=IDLE, counters=0, rx_data=0, rx_valid=0, frame_err=0,
//    parity_err=0, busy=0. Reset mid-frame aborts the frame; no rx_valid is produced.
//  - rx passes through a 2-FF synchronizer (rx_s); all decisions use rx_s only.
//  - State and counters advance only on clk edges with rx_tick=1. rx_valid drops on the next clk.
//  - tick_cnt width: $clog2(OVERSAMPLE). bit_idx width: $clog2(DATA_BITS).
//  - IDLE: rx_s==0 on a tick -> START, tick_cnt=0.
//  - START: tick_cnt++ each tick. At tick_cnt==OVERSAMPLE/2-1:
//      rx_s==0 -> DATA, tick_cnt=0, bit_idx=0.
//      rx_s==1 -> IDLE (glitch rejected, no output).
//  - DATA: at tick_cnt==OVERSAMPLE-1, shift rx_s into the MSB of shreg (shift right, LSB first),
//    then tick_cnt=0 and bit_idx++. After bit DATA_BITS-1 -> PARITY if PARITY_EN, else STOP.
//  - PARITY: at tick_cnt==OVERSAMPLE-1 sample p. Compute perr = ^shreg ^ p ^ PARITY_ODD.
//    -> STOP.
//  - STOP: at tick_cnt==OVERSAMPLE-1:
//      rx_data<=shreg; rx_valid<=1; frame_err<=~rx_s; parity_err<=perr.
//      rx_s==1 -> IDLE. rx_s==0 -> BREAK.
//  - BREAK: wait for rx_s==1 on a tick -> IDLE. A line held low produces exactly one frame.
//  - Data is delivered even on a framing or parity error. Flags are registered with rx_valid
//    and held until the next rx_valid.
//  - Latency: rx_valid is high the clk after the tick that samples mid-stop. There are 2 clk
//    of synchronizer delay at the front.
//  - Back-to-back frames: return to IDLE at mid-stop, so a start edge at the next bit boundary
//    is caught. No idle gap is required.
//  - No backpressure: a new frame overwrites rx_data. The consumer must take the word on rx_valid.
//  - Start-edge detection is quantized to 1 tick. Tolerated baud mismatch is about +/-3%.
// STRUCTURE
//  - uart_pkg: state encoding localparams (IDLE, START, DATA, PARITY, STOP, BREAK) and default
//    DATA_BITS/OVERSAMPLE. These are shared with the transmitter.
//  - Sub-module uart_rx_sync: 2-FF synchronizer, reset value 1, parameterized width.
//  - Top: FSM, tick_cnt, bit_idx, shreg, output registers.
// TESTING  (bench drives rx at exactly OVERSAMPLE rx_ticks per bit unless stated)
//  1. 8N1 frame 0x55 -> one rx_valid, rx_data=0x55, frame_err=0, parity_err=0, busy low after.
//  2. rx low for 4 ticks then high on an idle line -> no rx_valid, returns to IDLE, busy
//     pulses only.
//  3. Frame 0xA3 with stop=0, then line held low for 3 bit times -> one rx_valid, rx_data=0xA3,
//     frame_err=1. No second rx_valid until rx returns high and a new frame is sent.
//  4. PARITY_EN=1, even: 0x07 with parity=1 -> parity_err=0. 0x07 with parity=0 -> parity_err=1.
//  5. Frames 0x00 then 0xFF with no idle gap -> two rx_valid pulses, data 0x00 then 0xFF,
//     no errors.
//  6. reset during data bit 4 of 0x3C -> outputs at reset values, no rx_valid. The next full
//     frame 0x3C gives rx_data=0x3C.

Source files
------------

// File: rtl/uart_rx_oversampled_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_rx_oversampled_pkg                                           |
// | Brief   : Shared UART state encoding and default frame geometry.            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package uart_rx_oversampled_pkg;

    localparam int unsigned DEF_DATA_BITS  = 8;
    localparam int unsigned DEF_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_oversampled_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_rx_oversampled_if                                            |
// | Brief   : Serial line / tick inputs and received-word outputs of the RX.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface uart_rx_oversampled_if
    import uart_rx_oversampled_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
);
    logic                 rx_tick;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 busy;

    modport master (
        output rx_tick, rx,
        input  rx_data, rx_valid, frame_err, parity_err, busy
    );

    modport slave (
        input  rx_tick, rx,
        output rx_data, rx_valid, frame_err, parity_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_oversampled_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_rx_sync                                                      |
// | Brief   : Two-flop synchronizer, resets to the idle (high) line level.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module uart_rx_sync
    import uart_rx_oversampled_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic [WIDTH-1:0] d_i,
    output logic      [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule
`default_nettype wire

// File: rtl/uart_rx_oversampled.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_rx_oversampled                                               |
// | Brief   : Oversampling UART receiver, centre-sampled bits, optional parity. |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module uart_rx_oversampled
    import uart_rx_oversampled_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  wire logic             clk,
    input  wire logic             reset,
    uart_rx_oversampled_if.slave  bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] c_HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] c_FULL_M1  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] c_LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic          c_ODD      = 1'(PARITY_ODD);

    logic                 rx_s;
    rx_state_e            state_q;
    logic [TW-1:0]        tick_cnt_q;
    logic [BW-1:0]        bit_idx_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 perr_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 parity_err_q;

    uart_rx_sync #(.WIDTH(1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.rx),
        .q_o   (rx_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            tick_cnt_q   <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            perr_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (bus.rx_tick) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (!rx_s) begin
                            state_q    <= ST_START;
                            tick_cnt_q <= '0;
                        end
                    end
                    // A start bit that is gone by mid-bit is treated as line noise.
                    ST_START: begin
                        if (tick_cnt_q == c_HALF_M1) begin
                            tick_cnt_q <= '0;
                            bit_idx_q  <= '0;
                            state_q    <= rx_s ? ST_IDLE : ST_DATA;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TW'(1);
                        end
                    end
                    ST_DATA: begin
                        if (tick_cnt_q == c_FULL_M1) begin
                            shreg_q    <= {rx_s, shreg_q[DATA_BITS-1:1]};
                            tick_cnt_q <= '0;
                            if (bit_idx_q == c_LAST_BIT) begin
                                bit_idx_q <= '0;
                                state_q   <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_idx_q <= bit_idx_q + BW'(1);
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TW'(1);
                        end
                    end
                    ST_PARITY: begin
                        if (tick_cnt_q == c_FULL_M1) begin
                            perr_q     <= (^shreg_q) ^ rx_s ^ c_ODD;
                            tick_cnt_q <= '0;
                            state_q    <= ST_STOP;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TW'(1);
                        end
                    end
                    // Leaving at mid-stop lets a back-to-back start edge be caught.
                    ST_STOP: begin
                        if (tick_cnt_q == c_FULL_M1) begin
                            rx_data_q    <= shreg_q;
                            rx_valid_q   <= 1'b1;
                            frame_err_q  <= ~rx_s;
                            parity_err_q <= perr_q;
                            tick_cnt_q   <= '0;
                            state_q      <= rx_s ? ST_IDLE : ST_BREAK;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TW'(1);
                        end
                    end
                    ST_BREAK: begin
                        if (rx_s) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.parity_err = parity_err_q;
    assign bus.busy       = (state_q != ST_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversampled.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_uart_rx_oversampled                                            |
// | Brief   : Scoreboard bench for the UART receiver (8N1 and even-parity DUTs).|
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_uart_rx_oversampled;
    localparam int OS = 16;

    typedef logic [9:0] exp_t;  // {data[7:0], frame_err, parity_err}

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       tick  = 1'b0;
    logic [1:0] tdiv  = 2'd0;
    logic       rx0   = 1'b1;
    logic       rx1   = 1'b1;

    int   n_pass  = 0;
    int   n_total = 0;
    int   vcnt0   = 0;
    int   vcnt1   = 0;
    int   v_snap  = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0;
    exp_t e1;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tdiv <= tdiv + 2'd1;
        tick <= (tdiv == 2'd3);
    end

    uart_rx_oversampled_if #(.DATA_BITS(8)) bus0 ();
    uart_rx_oversampled_if #(.DATA_BITS(8)) bus1 ();

    assign bus0.rx_tick = tick;
    assign bus0.rx      = rx0;
    assign bus1.rx_tick = tick;
    assign bus1.rx      = rx1;

    uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    function automatic void push_exp(input int sel, input logic [7:0] d,
                                     input logic fe, input logic pe);
        if (sel == 0) q0.push_back({d, fe, pe});
        else          q1.push_back({d, fe, pe});
    endfunction

    always @(negedge clk) begin
        if (bus0.rx_valid === 1'b1) begin
            vcnt0++;
            if (q0.size() == 0) check("dut0 unexpected rx_valid", 32'd1, 32'd0);
            else begin
                e0 = q0.pop_front();
                check("dut0 rx_data",    32'(bus0.rx_data),    32'(e0[9:2]));
                check("dut0 frame_err",  32'(bus0.frame_err),  32'(e0[1]));
                check("dut0 parity_err", 32'(bus0.parity_err), 32'(e0[0]));
            end
        end
        if (bus1.rx_valid === 1'b1) begin
            vcnt1++;
            if (q1.size() == 0) check("dut1 unexpected rx_valid", 32'd1, 32'd0);
            else begin
                e1 = q1.pop_front();
                check("dut1 rx_data",    32'(bus1.rx_data),    32'(e1[9:2]));
                check("dut1 frame_err",  32'(bus1.frame_err),  32'(e1[1]));
                check("dut1 parity_err", 32'(bus1.parity_err), 32'(e1[0]));
            end
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (tick !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    task automatic drive(input int sel, input logic v);
        if (sel == 0) rx0 = v;
        else          rx1 = v;
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input logic use_par,
                              input logic pbit, input logic stop);
        drive(sel, 1'b0);
        wait_ticks(OS);
        for (int i = 0; i < 8; i++) begin
            drive(sel, d[i]);
            wait_ticks(OS);
        end
        if (use_par) begin
            drive(sel, pbit);
            wait_ticks(OS);
        end
        drive(sel, stop);
        wait_ticks(OS);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset rx_data",    32'(bus0.rx_data),    32'h0);
        check("reset rx_valid",   32'(bus0.rx_valid),   32'h0);
        check("reset frame_err",  32'(bus0.frame_err),  32'h0);
        check("reset parity_err", 32'(bus0.parity_err), 32'h0);
        check("reset busy",       32'(bus0.busy),       32'h0);
        reset = 1'b0;
        wait_ticks(4);

        // Plain 8N1 frame
        push_exp(0, 8'h55, 1'b0, 1'b0);
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
        wait_ticks(OS);
        check("t1 valid count", 32'(vcnt0), 32'd1);
        check("t1 busy after",  32'(bus0.busy), 32'h0);
        check("t1 data held",   32'(bus0.rx_data), 32'h55);

        // Short low glitch on idle line
        v_snap = vcnt0;
        rx0 = 1'b0;
        wait_ticks(2);
        check("t2 busy during glitch", 32'(bus0.busy), 32'h1);
        wait_ticks(2);
        rx0 = 1'b1;
        wait_ticks(OS);
        check("t2 busy after glitch", 32'(bus0.busy), 32'h0);
        check("t2 no rx_valid",       32'(vcnt0), 32'(v_snap));

        // Framing error followed by a held-low line
        v_snap = vcnt0;
        push_exp(0, 8'hA3, 1'b1, 1'b0);
        send_frame(0, 8'hA3, 1'b0, 1'b0, 1'b0);
        wait_ticks(3 * OS);
        check("t3 busy in break",  32'(bus0.busy), 32'h1);
        check("t3 one rx_valid",   32'(vcnt0), 32'(v_snap + 1));
        check("t3 frame_err",      32'(bus0.frame_err), 32'h1);
        rx0 = 1'b1;
        wait_ticks(4);
        check("t3 busy after release", 32'(bus0.busy), 32'h0);
        check("t3 frame_err held",     32'(bus0.frame_err), 32'h1);
        check("t3 still one rx_valid", 32'(vcnt0), 32'(v_snap + 1));

        // Even parity: 0x07 has three ones, so a parity bit of 1 is correct
        push_exp(1, 8'h07, 1'b0, 1'b0);
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
        push_exp(1, 8'h07, 1'b0, 1'b1);
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        wait_ticks(OS);
        check("t4 valid count", 32'(vcnt1), 32'd2);

        // Back-to-back frames with no idle gap
        v_snap = vcnt0;
        push_exp(0, 8'h00, 1'b0, 1'b0);
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
        push_exp(0, 8'hFF, 1'b0, 1'b0);
        send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
        wait_ticks(OS);
        check("t5 two rx_valid", 32'(vcnt0), 32'(v_snap + 2));

        // Reset in the middle of data bit 4 of 0x3C
        v_snap = vcnt0;
        rx0 = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < 4; i++) begin
            rx0 = (i == 2 || i == 3);
            wait_ticks(OS);
        end
        rx0 = 1'b1;
        wait_ticks(OS / 2);
        reset = 1'b1;
        #2;
        check("t6 reset rx_data",   32'(bus0.rx_data),   32'h0);
        check("t6 reset frame_err", 32'(bus0.frame_err), 32'h0);
        check("t6 reset busy",      32'(bus0.busy),      32'h0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        wait_ticks(2 * OS);
        check("t6 no rx_valid", 32'(vcnt0), 32'(v_snap));
        push_exp(0, 8'h3C, 1'b0, 1'b0);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        wait_ticks(OS);
        check("t6 rx_data after", 32'(bus0.rx_data), 32'h3C);
        check("t6 valid count",   32'(vcnt0), 32'(v_snap + 1));

        check("dut0 scoreboard drained", 32'(q0.size()), 32'd0);
        check("dut1 scoreboard drained", 32'(q1.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
